// File: rtl/pc_seq_unit_if.sv
// Command/status bundle between the control unit (master) and the PC unit (slave).
interface pc_seq_unit_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic [WIDTH-1:0] i_data;
  logic [WIDTH-1:0] i_offset;
  logic             i_writeEn;
  logic             i_branchEn;
  logic             i_incEn;
  logic             i_stall;
  logic             i_readEn;
  logic             i_call;
  logic             i_ret;
  logic [WIDTH-1:0] o_data;
  logic             o_misalign;
  logic             o_ras_ovf;
  logic             o_ras_unf;

  modport master (
    output i_data, i_offset, i_writeEn, i_branchEn, i_incEn,
           i_stall, i_readEn, i_call, i_ret,
    input  o_data, o_misalign, o_ras_ovf, o_ras_unf
  );

  modport slave (
    input  i_data, i_offset, i_writeEn, i_branchEn, i_incEn,
           i_stall, i_readEn, i_call, i_ret,
    output o_data, o_misalign, o_ras_ovf, o_ras_unf
  );
endinterface

// File: rtl/pc_seq_unit.sv
// Program counter with stall, absolute load, relative branch and optional return-address stack (macro PC_RAS_EN).
// One-cycle update latency, no backpressure: each edge applies the highest-priority command and drops the rest.
module pc_seq_unit #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      STEP      = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int unsigned      RAS_DEPTH = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  pc_seq_unit_if.slave  bus
);
  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ALIGN_MASK = STEP_W - WIDTH'(1);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_nxt;
  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_pc_br;
  logic [WIDTH-1:0] w_ras_top;
  logic             r_misalign;
  logic             w_call;
  logic             w_ret;
  logic             w_ras_empty;
  logic             w_push;
  logic             w_pop;

  assign w_pc_inc = r_pc + STEP_W;
  assign w_pc_br  = r_pc + bus.i_offset;

  // Only one of push/pop can win an edge; both lose to stall, load and branch.
  assign w_push = !bus.i_stall && !bus.i_writeEn && !bus.i_branchEn && w_call;
  assign w_pop  = !bus.i_stall && !bus.i_writeEn && !bus.i_branchEn && !w_call && w_ret;

`ifdef PC_RAS_EN
  localparam int unsigned PW   = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL = (PW + 1)'(RAS_DEPTH);

  logic [WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]    r_ras_ptr;
  logic [PW-1:0]    w_top_idx;
  logic [PW:0]      r_ras_cnt;
  logic             r_ras_ovf;
  logic             r_ras_unf;

  assign w_call      = bus.i_call;
  assign w_ret       = bus.i_ret;
  assign w_ras_empty = (r_ras_cnt == '0);
  assign w_top_idx   = r_ras_ptr - PW'(1);
  assign w_ras_top   = r_ras[w_top_idx];

  // r_ras_ptr is the next write slot; wrapping over the oldest entry is the overflow policy.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ras_ptr <= '0;
      r_ras_cnt <= '0;
      r_ras_ovf <= 1'b0;
      r_ras_unf <= 1'b0;
    end else if (w_push) begin
      r_ras_ptr <= r_ras_ptr + PW'(1);
      if (r_ras_cnt == FULL) r_ras_ovf <= 1'b1;
      else                   r_ras_cnt <= r_ras_cnt + (PW + 1)'(1);
    end else if (w_pop) begin
      if (w_ras_empty) begin
        r_ras_unf <= 1'b1;
      end else begin
        r_ras_ptr <= w_top_idx;
        r_ras_cnt <= r_ras_cnt - (PW + 1)'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_ras[r_ras_ptr] <= w_pc_inc;
  end

  assign bus.o_ras_ovf = r_ras_ovf;
  assign bus.o_ras_unf = r_ras_unf;
`else
  logic w_unused_ras;

  assign w_call        = 1'b0;
  assign w_ret         = 1'b0;
  assign w_ras_empty   = 1'b1;
  assign w_ras_top     = '0;
  assign w_unused_ras  = ^{bus.i_call, bus.i_ret};
  assign bus.o_ras_ovf = 1'b0;
  assign bus.o_ras_unf = 1'b0;
`endif

  always_comb begin
    w_pc_nxt = r_pc;
    if (bus.i_stall)         w_pc_nxt = r_pc;
    else if (bus.i_writeEn)  w_pc_nxt = bus.i_data;
    else if (bus.i_branchEn) w_pc_nxt = w_pc_br;
    else if (w_push)         w_pc_nxt = bus.i_data;
    else if (w_pop)          w_pc_nxt = w_ras_empty ? w_pc_inc : w_ras_top;
    else if (bus.i_incEn)    w_pc_nxt = w_pc_inc;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc       <= RESET_VEC;
      r_misalign <= |(RESET_VEC & ALIGN_MASK);
    end else begin
      r_pc       <= w_pc_nxt;
      r_misalign <= |(w_pc_nxt & ALIGN_MASK);
    end
  end

  assign bus.o_data     = bus.i_readEn ? r_pc : '0;
  assign bus.o_misalign = r_misalign;
endmodule

// File: tb/tb_pc_seq_unit.sv
// Randomised and directed bench for pc_seq_unit against a queue-based reference model.
module tb_pc_seq_unit;
  localparam int unsigned WIDTH     = 32;
  localparam int unsigned STEP      = 4;
  localparam logic [31:0] RESET_VEC = 32'h0;
`ifdef PC_RAS_EN
  localparam int unsigned RAS_D  = 2;
  localparam bit          RAS_ON = 1'b1;
`else
  localparam int unsigned RAS_D  = 8;
  localparam bit          RAS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_seq_unit_if #(.WIDTH(WIDTH)) bus ();

  pc_seq_unit #(
    .WIDTH(WIDTH), .STEP(STEP), .RESET_VEC(RESET_VEC), .RAS_DEPTH(RAS_D)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  logic        m_ovf;
  logic        m_unf;

  function automatic logic exp_mis(input logic [31:0] pc);
    return (pc % STEP) != 0;
  endfunction

  task automatic model_reset();
    m_pc = RESET_VEC;
    m_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic clear_cmds();
    bus.i_writeEn  = 1'b0;
    bus.i_branchEn = 1'b0;
    bus.i_incEn    = 1'b0;
    bus.i_stall    = 1'b0;
    bus.i_call     = 1'b0;
    bus.i_ret      = 1'b0;
    bus.i_data     = '0;
    bus.i_offset   = '0;
  endtask

  // Apply the current inputs to the model, then let the DUT take the same edge.
  task automatic cycle();
    if (!bus.i_stall) begin
      if (bus.i_writeEn) m_pc = bus.i_data;
      else if (bus.i_branchEn) m_pc = m_pc + bus.i_offset;
      else if (RAS_ON && bus.i_call) begin
        m_q.push_back(m_pc + STEP);
        if (m_q.size() > RAS_D) begin
          void'(m_q.pop_front());
          m_ovf = 1'b1;
        end
        m_pc = bus.i_data;
      end else if (RAS_ON && bus.i_ret) begin
        if (m_q.size() > 0) m_pc = m_q.pop_back();
        else begin
          m_pc = m_pc + STEP;
          m_unf = 1'b1;
        end
      end else if (bus.i_incEn) m_pc = m_pc + STEP;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] v);
    clear_cmds();
    bus.i_writeEn = 1'b1;
    bus.i_data    = v;
    cycle();
    clear_cmds();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_cmds();
    bus.i_readEn = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.o_data !== RESET_VEC) begin n_err++; $display("FAIL reset_pc: got %h want %h", bus.o_data, RESET_VEC); end
    n_checks++; if (bus.o_misalign !== exp_mis(RESET_VEC)) begin n_err++; $display("FAIL reset_mis: got %b want %b", bus.o_misalign, exp_mis(RESET_VEC)); end
    n_checks++; if ({bus.o_ras_ovf, bus.o_ras_unf} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b want 00", {bus.o_ras_ovf, bus.o_ras_unf}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_increment();
    bus.i_incEn = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cycle();
      n_checks++; if (bus.o_data !== 32'(4 * i)) begin n_err++; $display("FAIL inc_pc[%0d]: got %h want %h", i, bus.o_data, 32'(4 * i)); end
    end
    bus.i_readEn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_checks++; if (bus.o_data !== 32'h0) begin n_err++; $display("FAIL readen_off[%0d]: got %h want 0", i, bus.o_data); end
    end
    bus.i_readEn = 1'b1;
    #1;
    n_checks++; if (bus.o_data !== 32'd24) begin n_err++; $display("FAIL inc_hidden: got %h want 00000018", bus.o_data); end
    clear_cmds();
  endtask

  task automatic test_priority();
    load(32'h100);
    bus.i_writeEn = 1'b1; bus.i_data = 32'h40;
    bus.i_branchEn = 1'b1; bus.i_offset = 32'd8;
    bus.i_incEn = 1'b1; bus.i_call = 1'b1; bus.i_ret = 1'b1;
    cycle();
    n_checks++; if (bus.o_data !== 32'h40) begin n_err++; $display("FAIL prio_write: got %h want 00000040", bus.o_data); end
    clear_cmds();
    bus.i_branchEn = 1'b1; bus.i_offset = -32'sd16; bus.i_incEn = 1'b1;
    cycle();
    n_checks++; if (bus.o_data !== 32'h30) begin n_err++; $display("FAIL prio_branch: got %h want 00000030", bus.o_data); end
    bus.i_stall = 1'b1; bus.i_writeEn = 1'b1; bus.i_data = 32'h77;
    cycle();
    n_checks++; if (bus.o_data !== 32'h30) begin n_err++; $display("FAIL prio_stall: got %h want 00000030", bus.o_data); end
    clear_cmds();
    cycle();
    n_checks++; if (bus.o_data !== 32'h30) begin n_err++; $display("FAIL hold: got %h want 00000030", bus.o_data); end
  endtask

  task automatic test_wrap_align();
    load(32'hFFFF_FFFC);
    bus.i_incEn = 1'b1;
    cycle();
    n_checks++; if (bus.o_data !== 32'h0) begin n_err++; $display("FAIL wrap: got %h want 0", bus.o_data); end
    load(32'h102);
    n_checks++; if (bus.o_misalign !== 1'b1) begin n_err++; $display("FAIL mis_load: got %b want 1", bus.o_misalign); end
    bus.i_incEn = 1'b1;
    cycle();
    n_checks++; if (bus.o_data !== 32'h106 || bus.o_misalign !== 1'b1) begin n_err++; $display("FAIL mis_inc: got %h/%b want 00000106/1", bus.o_data, bus.o_misalign); end
    load(32'h200);
    n_checks++; if (bus.o_misalign !== 1'b0) begin n_err++; $display("FAIL mis_clear: got %b want 0", bus.o_misalign); end
  endtask

  task automatic test_async_reset();
    load(32'h1000);
    bus.i_ret = 1'b1;
    cycle();
    bus.i_ret = 1'b0;
    bus.i_incEn = 1'b1;
    repeat (3) cycle();
    n_checks++; if (bus.o_data !== m_pc) begin n_err++; $display("FAIL pre_reset: got %h want %h", bus.o_data, m_pc); end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    n_checks++; if (bus.o_data !== RESET_VEC) begin n_err++; $display("FAIL async_rst_pc: got %h want %h", bus.o_data, RESET_VEC); end
    n_checks++; if ({bus.o_ras_ovf, bus.o_ras_unf, bus.o_misalign} !== 3'b000) begin n_err++; $display("FAIL async_rst_flags: got %b want 000", {bus.o_ras_ovf, bus.o_ras_unf, bus.o_misalign}); end
    @(posedge clk);
    #1;
    n_checks++; if (bus.o_data !== RESET_VEC) begin n_err++; $display("FAIL rst_held: got %h want %h", bus.o_data, RESET_VEC); end
    @(negedge clk);
    rst = 1'b0;
    clear_cmds();
  endtask

`ifdef PC_RAS_EN
  task automatic test_ras();
    logic [31:0] want_pc[6];
    logic [1:0]  want_fl[6];
    want_pc = '{32'h100, 32'h200, 32'h300, 32'h204, 32'h104, 32'h108};
    want_fl = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b11};
    load(32'h10);
    for (int i = 0; i < 6; i++) begin
      clear_cmds();
      if (i < 3) begin
        bus.i_call = 1'b1;
        bus.i_ret  = (i == 1);
        bus.i_data = 32'(32'h100 * (i + 1));
      end else begin
        bus.i_ret = 1'b1;
      end
      cycle();
      n_checks++; if (bus.o_data !== want_pc[i] || {bus.o_ras_ovf, bus.o_ras_unf} !== want_fl[i]) begin n_err++; $display("FAIL ras_step[%0d]: got %h/%b want %h/%b", i, bus.o_data, {bus.o_ras_ovf, bus.o_ras_unf}, want_pc[i], want_fl[i]); end
    end
    clear_cmds();
  endtask
`else
  task automatic test_no_ras();
    load(32'h20);
    bus.i_call = 1'b1; bus.i_incEn = 1'b1; bus.i_data = 32'h999;
    cycle();
    n_checks++; if (bus.o_data !== 32'h24) begin n_err++; $display("FAIL noras_call: got %h want 00000024", bus.o_data); end
    bus.i_call = 1'b0; bus.i_ret = 1'b1;
    cycle();
    n_checks++; if (bus.o_data !== 32'h28) begin n_err++; $display("FAIL noras_ret: got %h want 00000028", bus.o_data); end
    bus.i_incEn = 1'b0;
    cycle();
    n_checks++; if (bus.o_data !== 32'h28 || {bus.o_ras_ovf, bus.o_ras_unf} !== 2'b00) begin n_err++; $display("FAIL noras_flags: got %h/%b want 00000028/00", bus.o_data, {bus.o_ras_ovf, bus.o_ras_unf}); end
    clear_cmds();
  endtask
`endif

  task automatic test_random();
    logic [31:0] want;
    for (int i = 0; i < 400; i++) begin
      bus.i_stall    = ($urandom_range(0, 7) == 0);
      bus.i_writeEn  = ($urandom_range(0, 5) == 0);
      bus.i_branchEn = ($urandom_range(0, 5) == 0);
      bus.i_call     = ($urandom_range(0, 4) == 0);
      bus.i_ret      = ($urandom_range(0, 3) == 0);
      bus.i_incEn    = $urandom_range(0, 1);
      bus.i_readEn   = ($urandom_range(0, 5) != 0);
      bus.i_data     = $urandom_range(0, 1) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
      bus.i_offset   = $urandom_range(0, 1) ? 32'($signed($urandom_range(0, 64)) - 32) : $urandom;
      cycle();
      want = bus.i_readEn ? m_pc : 32'h0;
      n_checks++; if (bus.o_data !== want || bus.o_misalign !== exp_mis(m_pc) || bus.o_ras_ovf !== m_ovf || bus.o_ras_unf !== m_unf) begin
        n_err++;
        $display("FAIL random[%0d]: got %h/%b%b%b want %h/%b%b%b", i, bus.o_data, bus.o_misalign, bus.o_ras_ovf, bus.o_ras_unf, want, exp_mis(m_pc), m_ovf, m_unf);
      end
    end
    clear_cmds();
    bus.i_readEn = 1'b1;
  endtask

  initial begin
    clear_cmds();
    bus.i_readEn = 1'b1;
    test_reset();
    test_increment();
    test_priority();
    test_wrap_align();
    test_async_reset();
`ifdef PC_RAS_EN
    test_ras();
`else
    test_no_ras();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
